updown_seq_arb: RTL and testbench

UPDOWN_SEQ_ARB -- requirements
Module: updown_seq_arb

---
 rtl/updown_seq_arb.sv | 116 +++++++++++
 tb/tb_updown_seq_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_arb.sv
// Two-requester arbiter driving a shared 3-bit up/down counter. Each grant runs
// len steps in the latched direction, then pulses done; abort and reset skip done.
// Ports: clk, rst (async, active-low), req/dir (per requester), len0/len1 (step
// counts), gnt (one-hot), busy, step (y moves next edge), done (pulse), y (count).
module updown_seq_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] dir,
    input  logic [2:0] len0,
    input  logic [2:0] len1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       step,
    output logic [1:0] done,
    output logic [2:0] y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] y_q, y_d;
    logic [2:0] rem_q, rem_d;
    logic [1:0] gnt_q, gnt_d;
    logic       dir_l_q, dir_l_d;
    logic       last_q, last_d;
    logic       win;
    logic       active;

    // On a tie the requester served least recently wins.
    always_comb begin
        win = 1'b0;
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
    end

    // Only the granted requester's req matters; dropping it aborts the run.
    assign active = |(req & gnt_q);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        rem_d   = rem_q;
        gnt_d   = gnt_q;
        dir_l_d = dir_l_q;
        last_d  = last_q;
        step    = 1'b0;
        done    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    dir_l_d = dir[win];
                    rem_d   = win ? len1 : len0;
                    state_d = (rem_d != 3'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (active) begin
                    step  = 1'b1;
                    y_d   = dir_l_q ? (y_q + 3'd1) : (y_q - 3'd1);
                    rem_d = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    rem_d   = 3'd0;
                    last_d  = gnt_q[1];
                end
            end
            DONE: begin
                done    = gnt_q;
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            y_q     <= 3'd0;
            rem_q   <= 3'd0;
            gnt_q   <= 2'b00;
            dir_l_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            gnt_q   <= gnt_d;
            dir_l_q <= dir_l_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign y    = y_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_updown_seq_arb.sv
// Scoreboard bench for updown_seq_arb: stimulus pushes expected grant/step/done
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_updown_seq_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] dir = 2'b00;
    logic [2:0] len0 = 3'd0;
    logic [2:0] len1 = 3'd0;
    logic [1:0] gnt;
    logic       busy;
    logic       step;
    logic [1:0] done;
    logic [2:0] y;

    updown_seq_arb dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dir  (dir),
        .len0 (len0),
        .len1 (len1),
        .gnt  (gnt),
        .busy (busy),
        .step (step),
        .done (done),
        .y    (y)
    );

    always #5 clk = ~clk;

    // kind: 0 = grant appears, 1 = y moved, 2 = done pulse
    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] val;
        logic [2:0] yv;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] ey = 3'd0;
    logic [2:0] prev_y = 3'd0;
    logic [1:0] prev_gnt = 2'b00;
    logic       step_s = 1'b0;

    function automatic string kname(input logic [1:0] k);
        case (k)
            2'd0:    return "grant";
            2'd1:    return "ystep";
            default: return "done";
        endcase
    endfunction

    task automatic push(input logic [1:0] k, input logic [1:0] v,
                        input logic [2:0] yy);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.yv   = yy;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [1:0] v,
                             input logic [2:0] yy);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s got val=%b y=%0d, none required",
                     kname(k), v, yy);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.yv != yy) begin
                errors++;
                $display("FAIL event got %s val=%b y=%0d, required %s val=%b y=%0d",
                         kname(k), v, yy, kname(e.kind), e.val, e.yv);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, act, req_v);
        end
    endtask

    // step is sampled after stimulus has settled inside the cycle
    always @(negedge clk) begin
        #3;
        step_s = step;
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_y   = y;
            prev_gnt = gnt;
        end else begin
            checks++;
            if ((y != prev_y) != step_s) begin
                errors++;
                $display("FAIL step_vs_y got step=%b y %0d->%0d", step_s,
                         prev_y, y);
            end
            if (y != prev_y) expect_ev(2'd1, 2'b00, y);
            if (gnt != prev_gnt && gnt != 2'b00) begin
                chk("idle_gap_gnt", {6'd0, prev_gnt}, 8'd0);
                expect_ev(2'd0, gnt, y);
            end
            if (done != 2'b00) expect_ev(2'd2, done, y);
            prev_y   = y;
            prev_gnt = gnt;
        end
    end

    task automatic wait_gnt();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL gnt_timeout got gnt=%b required nonzero", gnt);
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout got done=%b required nonzero", done);
        end
    endtask

    // Full transaction for one requester; inputs are scrambled after the
    // grant to show they are latched.
    task automatic run_txn(input int idx, input logic d, input logic [2:0] n);
        logic [1:0] g;
        g = (idx == 1) ? 2'b10 : 2'b01;
        push(2'd0, g, ey);
        for (int k = 0; k < n; k++) begin
            ey = d ? ey + 3'd1 : ey - 3'd1;
            push(2'd1, 2'b00, ey);
        end
        push(2'd2, g, ey);
        @(negedge clk);
        #1;
        dir[idx] = d;
        if (idx == 1) len1 = n;
        else len0 = n;
        req[idx] = 1'b1;
        @(negedge clk);
        wait_gnt();
        #1;
        dir  = ~dir;
        len0 = ~len0;
        len1 = ~len1;
        wait_done();
        #1;
        req = 2'b00;
        @(negedge clk);
        chk("post_gnt", {6'd0, gnt}, 8'd0);
        chk("post_busy", {7'd0, busy}, 8'd0);
        chk("post_y", {5'd0, y}, {5'd0, ey});
    endtask

    initial begin
        int ndone;
        #1 rst = 1'b0;
        #1;
        chk("rst_y", {5'd0, y}, 8'd0);
        chk("rst_gnt", {6'd0, gnt}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_step", {7'd0, step}, 8'd0);
        chk("rst_done", {6'd0, done}, 8'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        run_txn(0, 1'b1, 3'd3);
        run_txn(0, 1'b1, 3'd3);
        run_txn(0, 1'b1, 3'd3);
        run_txn(0, 1'b0, 3'd3);
        run_txn(1, 1'b0, 3'd0);

        // abort: up 5 from 6, req dropped once y reaches 0
        push(2'd0, 2'b01, ey);
        ey = ey + 3'd1;
        push(2'd1, 2'b00, ey);
        ey = ey + 3'd1;
        push(2'd1, 2'b00, ey);
        @(negedge clk);
        #1;
        dir[0] = 1'b1;
        len0   = 3'd5;
        req    = 2'b01;
        @(negedge clk);
        wait_gnt();
        repeat (2) @(negedge clk);
        chk("abort_y_before", {5'd0, y}, 8'd0);
        #1 req = 2'b00;
        @(negedge clk);
        chk("abort_gnt", {6'd0, gnt}, 8'd0);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {6'd0, done}, 8'd0);
        chk("abort_y", {5'd0, y}, 8'd0);
        repeat (3) @(negedge clk);
        chk("abort_y_hold", {5'd0, y}, 8'd0);

        // async reset during a run: down 4 from 0, reset after first step
        push(2'd0, 2'b10, ey);
        push(2'd1, 2'b00, 3'd7);
        #1;
        dir[1] = 1'b0;
        len1   = 3'd4;
        req    = 2'b10;
        @(negedge clk);
        wait_gnt();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_y", {5'd0, y}, 8'd0);
        chk("arst_gnt", {6'd0, gnt}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {6'd0, done}, 8'd0);
        chk("arst_queue", exp_q.size(), 8'd0);
        ey = 3'd0;
        @(negedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        #1 rst = 1'b1;

        // tie held: serves 0 (up 1), then 1 (down 2), then 0 (up 1)
        push(2'd0, 2'b01, 3'd0);
        push(2'd1, 2'b00, 3'd1);
        push(2'd2, 2'b01, 3'd1);
        push(2'd0, 2'b10, 3'd1);
        push(2'd1, 2'b00, 3'd0);
        push(2'd1, 2'b00, 3'd7);
        push(2'd2, 2'b10, 3'd7);
        push(2'd0, 2'b01, 3'd7);
        push(2'd1, 2'b00, 3'd0);
        push(2'd2, 2'b01, 3'd0);
        @(negedge clk);
        #1;
        dir  = 2'b01;
        len0 = 3'd1;
        len1 = 3'd2;
        req  = 2'b11;
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 3; i++) begin
            @(negedge clk);
            if (done != 2'b00) ndone++;
        end
        chk("tie_done_count", ndone[7:0], 8'd3);
        #1 req = 2'b00;
        repeat (3) @(negedge clk);
        chk("tie_y", {5'd0, y}, 8'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_empty", exp_q.size(), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
